// File: rtl/video_sync_conditioner.sv
// Purpose : conditions VGA timing (RGB, hsync, vsync, display enable) for the HDMI encoder.
// Latency : RGB/hsync PIX_DELAY clocks, de BLNK_SETTLE+1 clocks, vsync follows the delayed hsync edge.
// Backpressure: none, this is a free-running pixel stream.
//
// Ports (all synchronous to clk_pixel, rising edge):
//   clk_pixel              pixel clock
//   breset                 asynchronous, active-high reset
//   r_in/g_in/b_in         pixel colour, COLOR_W bits each
//   hsync_n_in/vsync_n_in  active-low syncs
//   de_in                  display enable, may glitch
//   r_out/g_out/b_out      colour delayed by PIX_DELAY
//   hsync_n_out            hsync delayed by PIX_DELAY
//   vsync_n_out            vsync retimed to an edge of the delayed hsync
//   de_out                 deglitched display enable
//   h_period/v_lines       line length (clocks) and frame height (lines)
//   sync_locked            line and frame timing repeat frame to frame
//
// Optional feature: define SYNC_STATS_EN to build the line/frame measurement
// logic. Without it h_period, v_lines and sync_locked are constant zero.
//
// Latency convention: an input present before sampling edge 0 shows up on
// the output after edge L. The colour/hsync path holds the input register
// plus PIX_DELAY delay stages, so it changes on the same edge as de_out when
// PIX_DELAY = BLNK_SETTLE+1.

module video_sync_conditioner #(
  parameter int COLOR_W     = 6,
  parameter int BLNK_SETTLE = 18,
  parameter int PIX_DELAY   = 19,
  parameter int VS_EDGE     = 0
) (
  input  logic               clk_pixel,
  input  logic               breset,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  input  logic               hsync_n_in,
  input  logic               vsync_n_in,
  input  logic               de_in,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out,
  output logic               hsync_n_out,
  output logic               vsync_n_out,
  output logic               de_out,
  output logic [15:0]        h_period,
  output logic [11:0]        v_lines,
  output logic               sync_locked
);

  localparam int CNT_W = $clog2(BLNK_SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLNK_SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------
  // Colour / hsync / vsync delay lines. Index 0 is the input register.
  // vsync only needs to reach the stage feeding the final hsync stage,
  // since vsync_n_out itself acts as its last stage.
  // ---------------------------------------------------------------------
  logic [COLOR_W-1:0] r_pipe  [0:PIX_DELAY];
  logic [COLOR_W-1:0] g_pipe  [0:PIX_DELAY];
  logic [COLOR_W-1:0] b_pipe  [0:PIX_DELAY];
  logic               hs_pipe [0:PIX_DELAY];
  logic               vs_pipe [0:PIX_DELAY-1];

  always_ff @(posedge clk_pixel or posedge breset) begin
    if (breset) begin
      for (int i = 0; i <= PIX_DELAY; i++) begin
        r_pipe[i]  <= '0;
        g_pipe[i]  <= '0;
        b_pipe[i]  <= '0;
        hs_pipe[i] <= 1'b1;
      end
      for (int i = 0; i < PIX_DELAY; i++) begin
        vs_pipe[i] <= 1'b1;
      end
    end else begin
      r_pipe[0]  <= r_in;
      g_pipe[0]  <= g_in;
      b_pipe[0]  <= b_in;
      hs_pipe[0] <= hsync_n_in;
      vs_pipe[0] <= vsync_n_in;
      for (int i = 1; i <= PIX_DELAY; i++) begin
        r_pipe[i]  <= r_pipe[i-1];
        g_pipe[i]  <= g_pipe[i-1];
        b_pipe[i]  <= b_pipe[i-1];
        hs_pipe[i] <= hs_pipe[i-1];
      end
      for (int i = 1; i < PIX_DELAY; i++) begin
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  assign r_out       = r_pipe[PIX_DELAY];
  assign g_out       = g_pipe[PIX_DELAY];
  assign b_out       = b_pipe[PIX_DELAY];
  assign hsync_n_out = hs_pipe[PIX_DELAY];

  // ---------------------------------------------------------------------
  // Display-enable deglitch. Any change between de_r and de_d restarts
  // the settle count; de_out only follows once the count drains to 1.
  // A change landing on the cnt==1 cycle takes the reload branch first,
  // so the pending update is dropped.
  // ---------------------------------------------------------------------
  logic             de_r;
  logic             de_d;
  logic [CNT_W-1:0] cnt;
  logic             de_q;

  always_ff @(posedge clk_pixel or posedge breset) begin
    if (breset) begin
      de_r <= 1'b0;
      de_d <= 1'b0;
      cnt  <= '0;
      de_q <= 1'b0;
    end else begin
      de_r <= de_in;
      de_d <= de_r;
      if (de_r != de_d) begin
        cnt <= CNT_LOAD;
      end else if (cnt == CNT_ONE) begin
        de_q <= de_r;
        cnt  <= '0;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  assign de_out = de_q;

  // ---------------------------------------------------------------------
  // vsync retime. The edge is detected one stage early (next vs current
  // value of the last hsync stage) so that vsync_n_out changes on the very
  // same clock as the hsync_n_out edge. The vsync value sampled is the one
  // travelling alongside that hsync sample.
  // ---------------------------------------------------------------------
  logic hs_edge;

  generate
    if (VS_EDGE == 0) begin : g_vs_trailing
      // active-low hsync returning high
      assign hs_edge = hs_pipe[PIX_DELAY-1] & ~hs_pipe[PIX_DELAY];
    end else begin : g_vs_leading
      // active-low hsync going low
      assign hs_edge = ~hs_pipe[PIX_DELAY-1] & hs_pipe[PIX_DELAY];
    end
  endgenerate

  logic vs_q;

  always_ff @(posedge clk_pixel or posedge breset) begin
    if (breset) begin
      vs_q <= 1'b1;
    end else if (hs_edge) begin
      vs_q <= vs_pipe[PIX_DELAY-1];
    end
  end

  assign vsync_n_out = vs_q;

`ifdef SYNC_STATS_EN
  // ---------------------------------------------------------------------
  // Line/frame measurement on the registered syncs. hcnt doubles as the
  // stall detector: it only reaches all-ones after 65535 clocks with no
  // hsync falling edge, which also drops the lock flag.
  // ---------------------------------------------------------------------
  logic        hs_r_d;
  logic        vs_r_d;
  logic        hs_fall;
  logic        vs_fall;
  logic [15:0] hcnt;
  logic [15:0] h_period_q;
  logic [15:0] h_period_last;
  logic [11:0] vcnt;
  logic [11:0] v_lines_q;
  logic        locked_q;

  assign hs_fall = ~hs_pipe[0] & hs_r_d;
  assign vs_fall = ~vs_pipe[0] & vs_r_d;

  always_ff @(posedge clk_pixel or posedge breset) begin
    if (breset) begin
      hs_r_d        <= 1'b1;
      vs_r_d        <= 1'b1;
      hcnt          <= '0;
      h_period_q    <= '0;
      h_period_last <= '0;
      vcnt          <= '0;
      v_lines_q     <= '0;
      locked_q      <= 1'b0;
    end else begin
      hs_r_d <= hs_pipe[0];
      vs_r_d <= vs_pipe[0];

      if (hs_fall) begin
        h_period_q <= (hcnt == '1) ? hcnt : hcnt + 16'd1;
        hcnt       <= '0;
      end else if (hcnt != '1) begin
        hcnt <= hcnt + 16'd1;
      end

      if (vs_fall) begin
        v_lines_q     <= vcnt;
        h_period_last <= h_period_q;
        locked_q      <= (h_period_q == h_period_last) && (vcnt == v_lines_q) &&
                         (h_period_q != '0) && (vcnt != '0);
        // a line starting on the frame edge belongs to the new frame
        vcnt          <= hs_fall ? 12'd1 : 12'd0;
      end else if (hs_fall && (vcnt != '1)) begin
        vcnt <= vcnt + 12'd1;
      end

      if (hcnt == '1) begin
        locked_q <= 1'b0;
      end
    end
  end

  assign h_period    = h_period_q;
  assign v_lines     = v_lines_q;
  assign sync_locked = locked_q;
`else
  assign h_period    = '0;
  assign v_lines     = '0;
  assign sync_locked = 1'b0;
`endif

endmodule
